// File: rtl/shift_deserializer_if.sv
// Parallel output stream of the serial receiver: word plus valid/ready handshake.
// The producer drives data_out/data_valid; the consumer drives data_ready.
interface shift_deserializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver: start(0) + WIDTH data bits + stop(1) sampled on a bit strobe,
// presented on a one-deep valid/ready output register with framing-error and overrun reporting.
module shift_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic                serial_in,
  input  logic                msb_first,
  shift_deserializer_if.master out_if,
  output logic                frame_err,
  output logic                overrun,
  output logic [CNT_W-1:0]    frame_err_cnt,
  output logic [CNT_W-1:0]    overrun_cnt
);

  localparam int             BCW      = $clog2(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt, data_q;
  logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
  logic             ord, ord_nxt;
  logic             valid_q;
  logic             load, fe_ev, ov_ev;
  logic             accept, out_free;

  assign accept   = valid_q & out_if.data_ready;
  // A word leaving at this edge frees the register for a word arriving at the same edge.
  assign out_free = ~valid_q | out_if.data_ready;

  assign out_if.data_out   = data_q;
  assign out_if.data_valid = valid_q;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    ord_nxt     = ord;
    load        = 1'b0;
    fe_ev       = 1'b0;
    ov_ev       = 1'b0;
    if (sample_en) begin
      unique case (state)
        IDLE: begin
          if (!serial_in) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
            ord_nxt     = msb_first;
          end
        end
        DATA: begin
          sr_nxt      = ord ? {sr[WIDTH-2:0], serial_in} : {serial_in, sr[WIDTH-1:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = STOP;
        end
        STOP: begin
          // A low stop bit is a framing error, never a fresh start bit.
          state_nxt = IDLE;
          if (!serial_in)    fe_ev = 1'b1;
          else if (out_free) load  = 1'b1;
          else               ov_ev = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sr            <= '0;
      bit_cnt       <= '0;
      ord           <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
      frame_err_cnt <= '0;
      overrun_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ord       <= ord_nxt;
      valid_q   <= load | (valid_q & ~accept);
      frame_err <= fe_ev;
      overrun   <= ov_ev;
      if (load) data_q <= sr;
      if (fe_ev && (frame_err_cnt != '1)) frame_err_cnt <= frame_err_cnt + 1'b1;
      if (ov_ev && (overrun_cnt != '1))   overrun_cnt   <= overrun_cnt + 1'b1;
    end
  end

endmodule
